// File: rtl/mealy_overlapping.sv
// Overlapping Mealy sequence detector; z rises in the cycle whose bit completes PATTERN.
// Define MEALY_OVERLAPPING_ONEHOT_EN for a one-hot state register; default is binary.
module mealy_overlapping #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int SW = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;

    // Longest proper prefix of PATTERN that is a suffix of (first k pattern bits, b).
    // A plain match (next bit agrees and k+1 < LEN) falls out as j = k+1.
    function automatic int fallback_len(input int k, input logic b);
        int                     best;
        int                     idx;
        logic                   ok;
        logic                   sb;
        logic [PATTERN_LEN-1:0] sh_s;
        logic [PATTERN_LEN-1:0] sh_p;
        best = 0;
        for (int j = 1; j < PATTERN_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    idx  = k + 1 - j + t;
                    sh_s = PATTERN >> (PATTERN_LEN - 1 - idx);
                    sh_p = PATTERN >> (PATTERN_LEN - 1 - t);
                    sb   = (idx == k) ? b : sh_s[0];
                    if (sb != sh_p[0]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    logic [SW-1:0] next_on0 [PATTERN_LEN];
    logic [SW-1:0] next_on1 [PATTERN_LEN];

    for (genvar k = 0; k < PATTERN_LEN; k++) begin : g_tbl
        assign next_on0[k] = SW'(fallback_len(k, 1'b0));
        assign next_on1[k] = SW'(fallback_len(k, 1'b1));
    end

`ifdef MEALY_OVERLAPPING_ONEHOT_EN

    typedef enum logic [PATTERN_LEN-1:0] {
        S_0    = PATTERN_LEN'(1),
        S_LAST = PATTERN_LEN'(1) << (PATTERN_LEN - 1)
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PATTERN_LEN-1:0] next_vec;
    logic                   onehot_ok;

    assign onehot_ok = (state != '0) && ((state & (state - 1'b1)) == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_0;
        end else begin
            state <= state_next;
        end
    end

    // Corrupted (non-one-hot) registers recover straight to S_0 with z low.
    always_comb begin
        next_vec = '0;
        z        = 1'b0;
        if (onehot_ok) begin
            for (int k = 0; k < PATTERN_LEN; k++) begin
                if (state[k]) begin
                    next_vec[x ? next_on1[k] : next_on0[k]] = 1'b1;
                end
            end
            z = rst && state[PATTERN_LEN-1] && (x == PATTERN[0]);
        end else begin
            next_vec = S_0;
        end
        state_next = state_t'(next_vec);
    end

`else

    typedef enum logic [SW-1:0] {
        S_0    = SW'(0),
        S_LAST = SW'(PATTERN_LEN - 1)
    } state_t;

    localparam logic [SW:0] NUM_STATES = (SW + 1)'(PATTERN_LEN);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_0;
        end else begin
            state <= state_next;
        end
    end

    // Codes at or above PATTERN_LEN are unused and fall back to S_0.
    always_comb begin
        state_next = S_0;
        z          = 1'b0;
        if ({1'b0, state} < NUM_STATES) begin
            state_next = state_t'(x ? next_on1[state] : next_on0[state]);
            z          = rst && (state == S_LAST) && (x == PATTERN[0]);
        end
    end

`endif

endmodule

// File: tb/tb_mealy_overlapping.sv
// Bench for mealy_overlapping: directed streams, a LEN=3 sweep instance and a random run
// checked against a sliding-window match model.
module tb_mealy_overlapping;

    localparam int LEN = 4;

    logic clk  = 1'b0;
    logic x    = 1'b0;
    logic rst  = 1'b0;
    logic z;
    logic x2   = 1'b0;
    logic rst2 = 1'b0;
    logic z2;

    int total = 0;
    int bad   = 0;

    logic [LEN-1:0] pat = 4'b1011;
    logic           hist[$];

    mealy_overlapping u_dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    mealy_overlapping #(
        .PATTERN_LEN (3),
        .PATTERN     (3'b111)
    ) u_sweep (
        .clk (clk),
        .rst (rst2),
        .x   (x2),
        .z   (z2)
    );

    always #5 clk = ~clk;

    // Drive one bit between edges, sample z mid-cycle, then let the edge consume it.
    task automatic apply(input logic b, input logic r, output logic act);
        @(negedge clk);
        x   = b;
        rst = r;
        #1;
        act = z;
        @(posedge clk);
    endtask

    task automatic apply2(input logic b, input logic r, output logic act);
        @(negedge clk);
        x2   = b;
        rst2 = r;
        #1;
        act = z2;
        @(posedge clk);
    endtask

    // Match iff the last LEN-1 bits since reset plus the current bit spell the pattern.
    function automatic logic model_z(input logic b, input logic r);
        logic hit;
        if (!r || hist.size() != LEN - 1) begin
            return 1'b0;
        end
        hit = (b == pat[0]);
        for (int i = 0; i < LEN - 1; i++) begin
            if (hist[i] != pat[LEN-1-i]) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

    task automatic model_step(input logic b, input logic r);
        if (!r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() > LEN - 1) begin
                void'(hist.pop_front());
            end
        end
    endtask

    task automatic test_reset;
        logic       act;
        logic [3:0] s    = 4'b1011;
        logic [3:0] want = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, act);
            total++;
            if (act !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: z=%b want 0", i, act);
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply(s[3-i], 1'b1, act);
            total++;
            if (act !== want[3-i]) begin
                bad++;
                $display("FAIL first_match bit %0d: z=%b want %b", i + 1, act, want[3-i]);
            end
        end
    endtask

    task automatic test_overlap;
        logic       act;
        logic [6:0] s    = 7'b1011011;
        logic [6:0] want = 7'b0001001;
        apply(1'b0, 1'b0, act);
        for (int i = 0; i < 7; i++) begin
            apply(s[6-i], 1'b1, act);
            total++;
            if (act !== want[6-i]) begin
                bad++;
                $display("FAIL overlap bit %0d: z=%b want %b", i + 1, act, want[6-i]);
            end
        end
    endtask

    task automatic test_fallback;
        logic       act;
        logic [4:0] s1 = 5'b11011;
        logic [4:0] w1 = 5'b00001;
        logic [6:0] s2 = 7'b1001011;
        logic [6:0] w2 = 7'b0000001;
        apply(1'b0, 1'b0, act);
        for (int i = 0; i < 5; i++) begin
            apply(s1[4-i], 1'b1, act);
            total++;
            if (act !== w1[4-i]) begin
                bad++;
                $display("FAIL fallback_11011 bit %0d: z=%b want %b", i + 1, act, w1[4-i]);
            end
        end
        apply(1'b0, 1'b0, act);
        for (int i = 0; i < 7; i++) begin
            apply(s2[6-i], 1'b1, act);
            total++;
            if (act !== w2[6-i]) begin
                bad++;
                $display("FAIL fallback_1001011 bit %0d: z=%b want %b", i + 1, act, w2[6-i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic       act;
        logic [2:0] pre  = 3'b101;
        logic [3:0] post = 4'b1011;
        logic [3:0] want = 4'b0001;
        apply(1'b0, 1'b0, act);
        for (int i = 0; i < 3; i++) begin
            apply(pre[2-i], 1'b1, act);
            total++;
            if (act !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_prefix bit %0d: z=%b want 0", i + 1, act);
            end
        end
        // x=1 here would complete 1011 without reset.
        apply(1'b1, 1'b0, act);
        total++;
        if (act !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_forced: z=%b want 0", act);
        end
        for (int i = 0; i < 4; i++) begin
            apply(post[3-i], 1'b1, act);
            total++;
            if (act !== want[3-i]) begin
                bad++;
                $display("FAIL mid_reset_after bit %0d: z=%b want %b", i + 1, act, want[3-i]);
            end
        end
    endtask

    task automatic test_sweep;
        logic       act;
        logic [5:0] want = 6'b001111;
        apply2(1'b1, 1'b0, act);
        total++;
        if (act !== 1'b0) begin
            bad++;
            $display("FAIL sweep_reset: z=%b want 0", act);
        end
        for (int i = 0; i < 6; i++) begin
            apply2(1'b1, 1'b1, act);
            total++;
            if (act !== want[5-i]) begin
                bad++;
                $display("FAIL sweep_111 bit %0d: z=%b want %b", i + 1, act, want[5-i]);
            end
        end
        apply2(1'b1, 1'b0, act);
        total++;
        if (act !== 1'b0) begin
            bad++;
            $display("FAIL sweep_reset_in_match: z=%b want 0", act);
        end
    endtask

    task automatic test_random;
        logic act;
        logic exp;
        logic b;
        logic r;
        apply(1'b0, 1'b0, act);
        model_step(1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            b   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 99) != 0);
            exp = model_z(b, r);
            apply(b, r, act);
            model_step(b, r);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL random bit %0d (x=%b rst=%b): z=%b want %b", i, b, r, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_fallback();
        test_mid_reset();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
